// File: rtl/m_cycle_sequencer_if.sv
// m_cycle_sequencer_if: control-unit <-> cycle sequencer signal bundle.
// Carries the microcode/interrupt inputs and the timing/IME outputs.
// The master modport is the sequencer's view; the slave modport is the
// consuming control unit's view.
interface m_cycle_sequencer_if #(
  parameter int unsigned MAX_MCYCLES = 8
);
  logic                   i_IR_Fetch;
  logic                   i_Halt_Req;
  logic                   i_EI_Req;
  logic                   i_EI_Now;
  logic                   i_DI_Req;
  logic [4:0]             i_IE;
  logic [4:0]             i_IF;
  logic [3:0]             o_Cycle_Step;
  logic [MAX_MCYCLES-1:0] o_Cycle_Count;
  logic                   o_IME;
  logic                   o_Halted;
  logic                   o_Int_Dispatch;
  logic [2:0]             o_Int_Vector;
  logic [4:0]             o_IF_Ack;
  logic                   o_Seq_Fault;

  modport master (
    input  i_IR_Fetch, i_Halt_Req, i_EI_Req, i_EI_Now, i_DI_Req, i_IE, i_IF,
    output o_Cycle_Step, o_Cycle_Count, o_IME, o_Halted, o_Int_Dispatch,
           o_Int_Vector, o_IF_Ack, o_Seq_Fault
  );

  modport slave (
    output i_IR_Fetch, i_Halt_Req, i_EI_Req, i_EI_Now, i_DI_Req, i_IE, i_IF,
    input  o_Cycle_Step, o_Cycle_Count, o_IME, o_Halted, o_Int_Dispatch,
           o_Int_Vector, o_IF_Ack, o_Seq_Fault
  );
endinterface

// File: rtl/m_cycle_sequencer.sv
// m_cycle_sequencer: CPU timing master.
// Generates the one-hot T-state and M-cycle buses, restarts the M-cycle
// count at every instruction fetch boundary, and owns IME / EI delay /
// HALT and the interrupt dispatch sequence.
// Optional feature: define SEQ_STALL_EN to add the i_Stall freeze input.
module m_cycle_sequencer #(
  parameter int unsigned MAX_MCYCLES = 8,
  parameter int unsigned DISPATCH_MC = 5
) (
  input  logic                i_Clk,
  input  logic                i_Reset,
`ifdef SEQ_STALL_EN
  input  logic                i_Stall,
`endif
  m_cycle_sequencer_if.master seq
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    HALT     = 2'd1,
    DISPATCH = 2'd2
  } state_t;

  localparam logic [MAX_MCYCLES-1:0] COUNT_ONE = MAX_MCYCLES'(1);
  localparam logic [3:0]             STEP_ONE  = 4'b0001;

  state_t                 state_q, state_d;
  logic [3:0]             step_q, step_d;
  logic [MAX_MCYCLES-1:0] count_q, count_d;
  logic                   ime_q, ime_d;
  logic                   ei_pend_q, ei_pend_d;
  logic [2:0]             vector_q, vector_d;
  logic                   fault_q, fault_d;

  logic                   freeze;
  logic [4:0]             pending;
  logic                   irq;
  logic                   t3;
  logic                   boundary;
  logic                   enter_dispatch;
  logic [4:0]             if_ack;

`ifdef SEQ_STALL_EN
  assign freeze = i_Stall;
`else
  assign freeze = 1'b0;
`endif

  // Index of the lowest set bit; bit 0 is the highest-priority source.
  function automatic logic [2:0] lowest_set(input logic [4:0] v);
    logic found;
    lowest_set = '0;
    found      = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      if (v[i] && !found) begin
        lowest_set = 3'(i);
        found      = 1'b1;
      end
    end
  endfunction

  assign pending  = seq.i_IE & seq.i_IF;
  assign irq      = |pending;
  assign t3       = step_q[3];
  assign boundary = (state_q == RUN) && t3 && seq.i_IR_Fetch;

  // State register and all sequencer-owned flags; reset wins over stall.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q   <= RUN;
      step_q    <= STEP_ONE;
      count_q   <= COUNT_ONE;
      ime_q     <= 1'b0;
      ei_pend_q <= 1'b0;
      vector_q  <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      count_q   <= count_d;
      ime_q     <= ime_d;
      ei_pend_q <= ei_pend_d;
      vector_q  <= vector_d;
      fault_q   <= fault_d;
    end
  end

  // Next-state: T-state rotation, M-cycle counting, FSM and IME rules.
  always_comb begin
    state_d        = state_q;
    step_d         = {step_q[2:0], step_q[3]};
    count_d        = count_q;
    ime_d          = ime_q;
    ei_pend_d      = ei_pend_q;
    vector_d       = vector_q;
    fault_d        = fault_q;
    enter_dispatch = 1'b0;

    // The dispatch decision uses ime_q, i.e. IME as it was before this
    // boundary's own EI/DI update.
    case (state_q)
      RUN: begin
        if (t3) begin
          if (boundary) begin
            count_d = COUNT_ONE;
            if (ime_q && irq) begin
              state_d        = DISPATCH;
              enter_dispatch = 1'b1;
            end else if (seq.i_Halt_Req) begin
              state_d = HALT;
            end
          end else if (count_q[MAX_MCYCLES-1]) begin
            count_d = COUNT_ONE;
            fault_d = 1'b1;
          end else begin
            count_d = count_q << 1;
          end
        end
      end
      HALT: begin
        count_d = COUNT_ONE;
        if (t3 && irq) begin
          if (ime_q) begin
            state_d        = DISPATCH;
            enter_dispatch = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      DISPATCH: begin
        if (t3) begin
          if (count_q[DISPATCH_MC-1]) begin
            state_d = RUN;
            count_d = COUNT_ONE;
          end else begin
            count_d = count_q << 1;
          end
        end
      end
      default: begin
        state_d = RUN;
        count_d = COUNT_ONE;
      end
    endcase

    // IME priority, lowest to highest: EI-pending promotion, EI capture,
    // EI_Now, DI at a boundary, dispatch entry.
    if (boundary) begin
      if (ei_pend_q) begin
        ime_d     = 1'b1;
        ei_pend_d = 1'b0;
      end
      if (seq.i_EI_Req) begin
        ei_pend_d = 1'b1;
      end
    end
    if (seq.i_EI_Now) begin
      ime_d = 1'b1;
    end
    if (boundary && seq.i_DI_Req) begin
      ime_d     = 1'b0;
      ei_pend_d = 1'b0;
    end
    if (enter_dispatch) begin
      ime_d    = 1'b0;
      vector_d = lowest_set(pending);
    end

    // A stall freezes every piece of sequencer state, T-state included.
    if (freeze) begin
      state_d   = state_q;
      step_d    = step_q;
      count_d   = count_q;
      ime_d     = ime_q;
      ei_pend_d = ei_pend_q;
      vector_d  = vector_q;
      fault_d   = fault_q;
    end
  end

  // IF acknowledge: one-clock pulse during T3 of dispatch M-cycle 3.
  always_comb begin
    if_ack = '0;
    if ((state_q == DISPATCH) && count_q[2] && t3 && !freeze) begin
      if_ack = 5'b00001 << vector_q;
    end
  end

  assign seq.o_Cycle_Step   = step_q;
  assign seq.o_Cycle_Count  = count_q;
  assign seq.o_IME          = ime_q;
  assign seq.o_Halted       = (state_q == HALT);
  assign seq.o_Int_Dispatch = (state_q == DISPATCH);
  assign seq.o_Int_Vector   = vector_q;
  assign seq.o_IF_Ack       = if_ack;
  assign seq.o_Seq_Fault    = fault_q;

endmodule

// File: tb/tb_m_cycle_sequencer.sv
// tb_m_cycle_sequencer: directed self-checking bench for m_cycle_sequencer.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_m_cycle_sequencer;
  localparam int unsigned MAXMC = 8;
  localparam int unsigned DMC   = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
`ifdef SEQ_STALL_EN
  logic        stall = 1'b0;
`endif
  int unsigned err_cnt = 0;
  int unsigned chk_cnt = 0;

  m_cycle_sequencer_if #(.MAX_MCYCLES(MAXMC)) bus ();

  m_cycle_sequencer #(
    .MAX_MCYCLES(MAXMC),
    .DISPATCH_MC(DMC)
  ) dut (
    .i_Clk   (clk),
    .i_Reset (rst),
`ifdef SEQ_STALL_EN
    .i_Stall (stall),
`endif
    .seq     (bus.master)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.i_IR_Fetch = 1'b0;
    bus.i_Halt_Req = 1'b0;
    bus.i_EI_Req   = 1'b0;
    bus.i_EI_Now   = 1'b0;
    bus.i_DI_Req   = 1'b0;
  endtask

  // Ends on a falling edge with reset just released: outputs hold reset values.
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One-M-cycle instruction from Step=0001: fetch (plus requests) on T3.
  task automatic instr(input logic ei, input logic di, input logic halt);
    tick(); tick(); tick();
    bus.i_IR_Fetch = 1'b1;
    bus.i_EI_Req   = ei;
    bus.i_DI_Req   = di;
    bus.i_Halt_Req = halt;
    tick();
    idle_inputs();
  endtask

  // Called on the first clock of dispatch; walks the 20 dispatch clocks.
  task automatic run_dispatch(input logic [2:0] vec, input logic [4:0] ack);
    for (int k = 0; k < 20; k++) begin
      check_val($sformatf("disp_active_%0d", k), 32'(bus.o_Int_Dispatch), 32'd1);
      check_val($sformatf("disp_ack_%0d", k), 32'(bus.o_IF_Ack), (k == 11) ? 32'(ack) : 32'd0);
      if (k % 4 == 0) begin
        check_val($sformatf("disp_count_%0d", k), 32'(bus.o_Cycle_Count), 32'd1 << (k / 4));
        check_val($sformatf("disp_vec_%0d", k), 32'(bus.o_Int_Vector), 32'(vec));
      end
      tick();
    end
    check_val("disp_done", 32'(bus.o_Int_Dispatch), 32'd0);
    check_val("disp_done_count", 32'(bus.o_Cycle_Count), 32'd1);
    check_val("disp_done_step", 32'(bus.o_Cycle_Step), 32'd1);
    check_val("disp_done_ime", 32'(bus.o_IME), 32'd0);
  endtask

  initial begin
    idle_inputs();
    bus.i_IE = '0;
    bus.i_IF = '0;

    // Reset values.
    do_reset();
    check_val("rst_step", 32'(bus.o_Cycle_Step), 32'h1);
    check_val("rst_count", 32'(bus.o_Cycle_Count), 32'h1);
    check_val("rst_ime", 32'(bus.o_IME), 32'd0);
    check_val("rst_halted", 32'(bus.o_Halted), 32'd0);
    check_val("rst_disp", 32'(bus.o_Int_Dispatch), 32'd0);
    check_val("rst_vec", 32'(bus.o_Int_Vector), 32'd0);
    check_val("rst_ack", 32'(bus.o_IF_Ack), 32'd0);
    check_val("rst_fault", 32'(bus.o_Seq_Fault), 32'd0);

    // Free-running rotation with no fetch.
    for (int k = 0; k < 12; k++) begin
      check_val($sformatf("rot_step_%0d", k), 32'(bus.o_Cycle_Step), 32'd1 << (k % 4));
      if (k % 4 == 0)
        check_val($sformatf("rot_count_%0d", k), 32'(bus.o_Cycle_Count), 32'd1 << (k / 4));
      tick();
    end
    check_val("rot_count_m4", 32'(bus.o_Cycle_Count), 32'h08);

    // Fetch on T3 of M-cycle 3 restarts the count.
    do_reset();
    for (int k = 0; k < 11; k++) tick();
    check_val("fetch_pre_step", 32'(bus.o_Cycle_Step), 32'h8);
    check_val("fetch_pre_count", 32'(bus.o_Cycle_Count), 32'h4);
    bus.i_IR_Fetch = 1'b1;
    tick();
    bus.i_IR_Fetch = 1'b0;
    check_val("fetch_step", 32'(bus.o_Cycle_Step), 32'h1);
    check_val("fetch_count", 32'(bus.o_Cycle_Count), 32'h1);

    // Overflow: Count wraps 80->01 and the fault flag sticks until reset.
    do_reset();
    for (int k = 0; k < 31; k++) tick();
    check_val("ovf_pre_count", 32'(bus.o_Cycle_Count), 32'h80);
    check_val("ovf_pre_fault", 32'(bus.o_Seq_Fault), 32'd0);
    tick();
    check_val("ovf_count", 32'(bus.o_Cycle_Count), 32'h01);
    check_val("ovf_fault", 32'(bus.o_Seq_Fault), 32'd1);
    for (int k = 0; k < 8; k++) tick();
    check_val("ovf_sticky", 32'(bus.o_Seq_Fault), 32'd1);
    check_val("ovf_count_after", 32'(bus.o_Cycle_Count), 32'h04);
    do_reset();
    check_val("ovf_cleared", 32'(bus.o_Seq_Fault), 32'd0);

    // EI delay then dispatch of source 2.
    instr(1'b1, 1'b0, 1'b0);
    check_val("ei_b1_ime", 32'(bus.o_IME), 32'd0);
    instr(1'b0, 1'b0, 1'b0);
    check_val("ei_b2_ime", 32'(bus.o_IME), 32'd1);
    bus.i_IE = 5'h04;
    bus.i_IF = 5'h06;
    instr(1'b0, 1'b0, 1'b0);
    check_val("irq_entry_disp", 32'(bus.o_Int_Dispatch), 32'd1);
    check_val("irq_entry_ime", 32'(bus.o_IME), 32'd0);
    run_dispatch(3'd2, 5'h04);
    bus.i_IE = '0;
    bus.i_IF = '0;

    // EI; DI back-to-back leaves IME clear.
    do_reset();
    instr(1'b1, 1'b0, 1'b0);
    instr(1'b0, 1'b1, 1'b0);
    check_val("eidi_ime_b2", 32'(bus.o_IME), 32'd0);
    instr(1'b0, 1'b0, 1'b0);
    check_val("eidi_ime_b3", 32'(bus.o_IME), 32'd0);

    // EI_Now sets IME next clock; DI at a boundary beats EI_Now.
    do_reset();
    bus.i_EI_Now = 1'b1;
    tick();
    bus.i_EI_Now = 1'b0;
    check_val("einow_ime", 32'(bus.o_IME), 32'd1);
    tick(); tick();
    bus.i_IR_Fetch = 1'b1;
    bus.i_DI_Req   = 1'b1;
    bus.i_EI_Now   = 1'b1;
    tick();
    idle_inputs();
    check_val("di_beats_einow", 32'(bus.o_IME), 32'd0);

    // HALT with IME clear: wake on pending IRQ without dispatch.
    do_reset();
    instr(1'b0, 1'b0, 1'b1);
    check_val("halt_entry", 32'(bus.o_Halted), 32'd1);
    for (int k = 0; k < 5; k++) begin
      check_val($sformatf("halt_count_%0d", k), 32'(bus.o_Cycle_Count), 32'h1);
      tick();
    end
    bus.i_IE = 5'h01;
    bus.i_IF = 5'h01;
    tick();
    check_val("halt_t2", 32'(bus.o_Halted), 32'd1);
    tick();
    check_val("halt_t3", 32'(bus.o_Halted), 32'd1);
    tick();
    check_val("wake_halted", 32'(bus.o_Halted), 32'd0);
    check_val("wake_disp", 32'(bus.o_Int_Dispatch), 32'd0);
    check_val("wake_count", 32'(bus.o_Cycle_Count), 32'h1);
    check_val("wake_step", 32'(bus.o_Cycle_Step), 32'h1);
    for (int k = 0; k < 4; k++) tick();
    check_val("wake_run_disp", 32'(bus.o_Int_Dispatch), 32'd0);
    check_val("wake_run_count", 32'(bus.o_Cycle_Count), 32'h2);
    bus.i_IE = '0;
    bus.i_IF = '0;

    // HALT with IME set: dispatch of source 4 straight out of HALT.
    do_reset();
    bus.i_EI_Now = 1'b1;
    tick();
    bus.i_EI_Now = 1'b0;
    tick(); tick();
    bus.i_IR_Fetch = 1'b1;
    bus.i_Halt_Req = 1'b1;
    tick();
    idle_inputs();
    check_val("halt2_entry", 32'(bus.o_Halted), 32'd1);
    check_val("halt2_ime", 32'(bus.o_IME), 32'd1);
    tick(); tick();
    bus.i_IE = 5'h18;
    bus.i_IF = 5'h10;
    tick();
    check_val("halt2_t3", 32'(bus.o_Halted), 32'd1);
    tick();
    check_val("halt2_exit", 32'(bus.o_Halted), 32'd0);
    check_val("halt2_ime_clr", 32'(bus.o_IME), 32'd0);
    run_dispatch(3'd4, 5'h10);

    // Dispatch wins over HALT at the same boundary; reset aborts dispatch.
    do_reset();
    bus.i_IE = 5'h03;
    bus.i_IF = 5'h02;
    bus.i_EI_Now = 1'b1;
    tick();
    bus.i_EI_Now = 1'b0;
    tick(); tick();
    bus.i_IR_Fetch = 1'b1;
    bus.i_Halt_Req = 1'b1;
    tick();
    idle_inputs();
    check_val("prio_disp", 32'(bus.o_Int_Dispatch), 32'd1);
    check_val("prio_halted", 32'(bus.o_Halted), 32'd0);
    check_val("prio_vec", 32'(bus.o_Int_Vector), 32'd1);
    for (int k = 0; k < 6; k++) tick();
    bus.i_IE = '0;
    bus.i_IF = '0;
    do_reset();
    check_val("abort_disp", 32'(bus.o_Int_Dispatch), 32'd0);
    check_val("abort_vec", 32'(bus.o_Int_Vector), 32'd0);
    check_val("abort_step", 32'(bus.o_Cycle_Step), 32'h1);
    check_val("abort_count", 32'(bus.o_Cycle_Count), 32'h1);

`ifdef SEQ_STALL_EN
    // Stall at Step=0100 freezes the sequencer; release resumes at 1000.
    do_reset();
    tick(); tick();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_val($sformatf("stall_step_%0d", k), 32'(bus.o_Cycle_Step), 32'h4);
      check_val($sformatf("stall_count_%0d", k), 32'(bus.o_Cycle_Count), 32'h1);
    end
    stall = 1'b0;
    tick();
    check_val("stall_resume", 32'(bus.o_Cycle_Step), 32'h8);
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
